// File: rtl/csoc_scan_target_pkg.sv
// Shared constants and small helpers for the CSoC scan/functional test-port target.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package csoc_scan_target_pkg;

  // Port geometry of the tester <-> CSoC link.
  localparam int NUM_CHAINS  = 8;
  localparam int SYNC_STAGES = 2;
  localparam int DATA_W      = 8;

  // test_tm selects between functional byte transfer and scan chains.
  typedef enum logic {
    MODE_FUNC = 1'b0,
    MODE_SCAN = 1'b1
  } mode_e;

  // 0->1 detector on a synchronised level and its one-cycle-delayed copy.
  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/csoc_scan_target_byte_fifo.sv
// Small byte FIFO with push/pop/flush, registered empty flag and occupancy count.
// Latency: push visible at o_head/o_empty the cycle after i_push; pop advances head next cycle.
// Backpressure: push on full is dropped (o_drop pulses) unless a pop is accepted in the same cycle.
// Ports: clk/rstn (async active-low), i_flush (sync clear), i_push/i_dat, i_pop,
//        o_head, o_full, o_empty, o_count, o_drop.
module byte_fifo
  #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
  )
  (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [W-1:0]  i_dat,
    input  logic          i_pop,
    output logic [W-1:0]  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count,
    output logic          o_drop
  );

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_empty;

  logic          w_full;
  logic          w_do_pop;
  logic          w_do_push;
  logic [CW-1:0] w_count_nxt;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & (r_count != '0);
  // A pop in the same cycle frees the slot, so a push on full is still accepted.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_nxt;
      // Empty is a flop of its own so downstream status lines cannot glitch.
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = r_empty;
  assign o_count = r_count;
  assign o_drop  = i_push & ~w_do_push;

endmodule

// File: rtl/csoc_scan_target.sv
// CSoC-side responder of the tester port: 8 scan chains (tm=1) or a byte FIFO (tm=0).
// Latency: csoc_clk / uart_read rise acts on the 3rd clk edge counting the first edge sampling it high.
// Backpressure: none towards the tester; pushes into a full FIFO are dropped and flag sticky overflow.
// Ports: clk/rstn system clock + async reset; csoc_clk (strobe), csoc_rstn (sync clear),
//        test_se/test_tm/data_i sampled at tick; uart_read pop request; uart_write FIFO
//        non-empty; data_o scan-out or FIFO head; overflow sticky drop flag.
module csoc_scan_target
  import csoc_scan_target_pkg::*;
  #(
    parameter int CHAIN_LEN  = 16,
    parameter int FIFO_DEPTH = 4
  )
  (
    input  logic              clk,
    input  logic              rstn,
    input  logic              csoc_clk,
    input  logic              csoc_rstn,
    input  logic              test_se,
    input  logic              test_tm,
    input  logic [DATA_W-1:0] data_i,
    input  logic              uart_read,
    output logic              uart_write,
    output logic [DATA_W-1:0] data_o,
    output logic              overflow
  );

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Synchronisers and edge detectors
  logic [SYNC_STAGES-1:0] r_cclk_sync;
  logic [SYNC_STAGES-1:0] r_crst_sync;
  logic [SYNC_STAGES-1:0] r_rd_sync;
  logic                   r_cclk_prev;
  logic                   r_rd_prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cclk_sync <= '0;
      r_crst_sync <= '0;
      r_rd_sync   <= '0;
      r_cclk_prev <= 1'b0;
      r_rd_prev   <= 1'b0;
    end else begin
      r_cclk_sync <= {r_cclk_sync[SYNC_STAGES-2:0], csoc_clk};
      r_crst_sync <= {r_crst_sync[SYNC_STAGES-2:0], csoc_rstn};
      r_rd_sync   <= {r_rd_sync[SYNC_STAGES-2:0], uart_read};
      r_cclk_prev <= r_cclk_sync[SYNC_STAGES-1];
      r_rd_prev   <= r_rd_sync[SYNC_STAGES-1];
    end
  end

  logic  w_tick;
  logic  w_pop_pulse;
  logic  w_clear;
  mode_e w_mode;

  assign w_tick      = rise(r_cclk_sync[SYNC_STAGES-1], r_cclk_prev);
  assign w_pop_pulse = rise(r_rd_sync[SYNC_STAGES-1], r_rd_prev);
  // Synced target reset wins over any tick or pop landing in the same cycle.
  assign w_clear     = ~r_crst_sync[SYNC_STAGES-1];
  // test_tm/se/data_i are held stable by the tester around the strobe, so no sync needed.
  assign w_mode      = mode_e'(test_tm);

  logic w_scan_tick;
  logic w_push;
  logic w_pop;

  assign w_scan_tick = w_tick & (w_mode == MODE_SCAN) & ~w_clear;
  assign w_push      = w_tick & (w_mode == MODE_FUNC) & ~w_clear;
  assign w_pop       = w_pop_pulse & (w_mode == MODE_FUNC) & ~w_clear;

  // Scan chains
  logic [NUM_CHAINS-1:0] w_scan_out;

  for (genvar g = 0; g < NUM_CHAINS; g++) begin : g_chain
    logic [CHAIN_LEN-1:0] r_chain;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_chain <= '0;
      end else if (w_clear) begin
        r_chain <= '0;
      end else if (w_scan_tick) begin
        // Capture stands in for the CUT response: invert the whole chain.
        r_chain <= test_se ? {r_chain[CHAIN_LEN-2:0], data_i[g]} : ~r_chain;
      end
    end

    assign w_scan_out[g] = r_chain[CHAIN_LEN-1];
  end

  // Functional FIFO
  logic [DATA_W-1:0] w_fifo_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CW-1:0]     w_fifo_count;
  logic              w_fifo_drop;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (w_clear),
    .i_push  (w_push),
    .i_dat   (data_i + 8'd1),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count),
    .o_drop  (w_fifo_drop)
  );

  logic r_overflow;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
    end else if (w_clear) begin
      r_overflow <= 1'b0;
    end else if (w_fifo_drop && w_fifo_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow   = r_overflow;
  assign uart_write = ~w_fifo_empty;
  assign data_o     = (w_mode == MODE_SCAN)   ? w_scan_out  :
                      (w_fifo_count != '0)    ? w_fifo_head : '0;

endmodule
